square_seq: RTL and testbench

//  Iterative shift-add fixed-point squarer; the inverse of the CORDIC square-root unit.

---
 rtl/sq_pkg.sv | 21 ++
 rtl/square_dp.sv | 76 +++++++
 rtl/square_seq.sv | 95 +++++++++
 tb/tb_square_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// Shared constants, state encoding and sizing helper for the iterative squarer.
package sq_pkg;

  // Default operand geometry: Q8.16 operand, Q16.16 square.
  localparam int SQ_IN_W   = 24;
  localparam int SQ_FRAC_W = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sq_state_e;

  // Width of the iteration counter for a given operand width.
  function automatic int ctr_w(input int in_w);
    return $clog2(in_w);
  endfunction

endpackage

// File: rtl/square_dp.sv
// Shift-add datapath for square_seq: holds multiplicand, multiplier and the
// 2*IN_W accumulator, performs one conditional add/shift per step, and
// presents the candidate final result (truncated, or rounded when the
// SQUARE_ROUND_EN macro is defined) computed from the post-add accumulator.
module square_dp
  import sq_pkg::*;
#(
  parameter int IN_W   = SQ_IN_W,
  parameter int FRAC_W = SQ_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [IN_W-1:0]          inp_num_i,
  output logic [2*IN_W-FRAC_W-1:0] res_next_o
);

  localparam int ACC_W = 2 * IN_W;
  localparam int OUT_W = 2 * IN_W - FRAC_W;

  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [IN_W-1:0]  mplier_q, mplier_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;

  // Accumulator value after this step's conditional add.
  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : {ACC_W{1'b0}});
  end

  // Next-state for the operand/accumulator registers: load wins over step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = {{IN_W{1'b0}}, inp_num_i};
      mplier_d = inp_num_i;
      acc_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

`ifdef SQUARE_ROUND_EN
  logic [OUT_W:0] rnd_sum;

  // Round-to-nearest on the first discarded bit, saturating at all-ones.
  always_comb begin
    rnd_sum    = {1'b0, acc_sum[ACC_W-1:FRAC_W]} + {{OUT_W{1'b0}}, acc_sum[FRAC_W-1]};
    res_next_o = rnd_sum[OUT_W] ? {OUT_W{1'b1}} : rnd_sum[OUT_W-1:0];
  end
`else
  // Plain truncation of the fractional bits below the output LSB.
  always_comb begin
    res_next_o = acc_sum[ACC_W-1:FRAC_W];
  end
`endif

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/square_seq.sv
// Iterative shift-add fixed-point squarer: Result = (InpNum*InpNum) >> FRAC_W.
// One multiplier bit is consumed per clock; Stop rises on the IN_W-th edge
// with Start=0 after the load edge. Optional macro SQUARE_ROUND_EN selects
// round-to-nearest instead of truncation (latency unchanged).
module square_seq
  import sq_pkg::*;
#(
  parameter int IN_W   = SQ_IN_W,
  parameter int FRAC_W = SQ_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     Start,
  input  logic [IN_W-1:0]          InpNum,
  output logic [2*IN_W-FRAC_W-1:0] Result,
  output logic                     Stop
);

  localparam int OUT_W = 2 * IN_W - FRAC_W;
  localparam int CTR_W = ctr_w(IN_W);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(IN_W - 1);

  sq_state_e        state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             stop_q, stop_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             load;
  logic             step;
  logic [OUT_W-1:0] res_next;

  square_dp #(
    .IN_W   (IN_W),
    .FRAC_W (FRAC_W)
  ) u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .step_i     (step),
    .inp_num_i  (InpNum),
    .res_next_o (res_next)
  );

  // Next-state, counter, done flag and result capture. The edge leaving
  // LOAD already performs the first iteration, so LOAD and RUN step alike.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    stop_d   = stop_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    if (Start) begin
      state_d = LOAD;
      ctr_d   = '0;
      stop_d  = 1'b0;
      load    = 1'b1;
    end else begin
      case (state_q)
        LOAD, RUN: begin
          step  = 1'b1;
          ctr_d = ctr_q + CTR_W'(1);
          if (ctr_q == CTR_LAST) begin
            state_d  = DONE;
            stop_d   = 1'b1;
            result_d = res_next;
          end else begin
            state_d = RUN;
          end
        end
        IDLE:    state_d = IDLE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      stop_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      stop_q   <= stop_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;
  assign Stop   = stop_q;

endmodule

// File: tb/tb_square_seq.sv
// Directed, table-driven bench for square_seq plus hand sequences for
// abort, held Start, DONE hold and asynchronous reset.
module tb_square_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] inp;
  logic [31:0] result;
  logic        stop;

  int checks;
  int errors;
  logic [31:0] last_res;

  typedef struct {
    logic [23:0] inp;
    logic [31:0] exp_trunc;
    logic [31:0] exp_round;
    string       name;
  } vec_t;

  vec_t vecs [6];

  square_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (start),
    .InpNum (inp),
    .Result (result),
    .Stop   (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  function automatic logic [31:0] pick(input vec_t v);
`ifdef SQUARE_ROUND_EN
    return v.exp_round;
`else
    return v.exp_trunc;
`endif
  endfunction

  // Load x on one edge, then run 24 edges; Stop must stay low through edge
  // 23 with the old Result held, then rise with the new Result on edge 24.
  task automatic do_run(input logic [23:0] x, input logic [31:0] exp,
                        input logic [31:0] held, input string nm);
    @(posedge clk); #1;
    start = 1'b1;
    inp   = x;
    @(posedge clk); #1;
    start = 1'b0;
    inp   = x ^ 24'hA5A5A5;   // must be ignored outside LOAD
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      if (e == 1) chk({nm, " stop_low_early"}, {31'd0, stop}, 32'd0);
      if (e == 23) begin
        chk({nm, " stop_low_e23"}, {31'd0, stop}, 32'd0);
        chk({nm, " held_e23"}, result, held);
      end
    end
    chk({nm, " stop_e24"}, {31'd0, stop}, 32'd1);
    chk({nm, " result"}, result, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{24'h010000, 32'h00010000, 32'h00010000, "one"};
    vecs[1] = '{24'h018000, 32'h00024000, 32'h00024000, "one_half"};
    vecs[2] = '{24'h020000, 32'h00040000, 32'h00040000, "two"};
    vecs[3] = '{24'hFFFFFF, 32'hFFFFFE00, 32'hFFFFFE00, "max"};
    vecs[4] = '{24'h000000, 32'h00000000, 32'h00000000, "zero"};
    vecs[5] = '{24'h0000B6, 32'h00000000, 32'h00000001, "tiny_b6"};

    rst_n = 1'b0;
    start = 1'b0;
    inp   = '0;
    #12;
    chk("reset stop", {31'd0, stop}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle stop", {31'd0, stop}, 32'd0);

    last_res = 32'd0;
    for (int i = 0; i < 6; i++) begin
      do_run(vecs[i].inp, pick(vecs[i]), last_res, vecs[i].name);
      last_res = pick(vecs[i]);
    end

    // DONE holds indefinitely.
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold stop", {31'd0, stop}, 32'd1);
    chk("done_hold result", result, last_res);

    // Establish a known Result, then abort a run at cycle 10.
    do_run(24'h010000, 32'h00010000, last_res, "pre_abort");
    last_res = 32'h00010000;
    @(posedge clk); #1;
    start = 1'b1;
    inp   = 24'h018000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort mid stop", {31'd0, stop}, 32'd0);
    chk("abort mid result", result, last_res);
    do_run(24'h020000, 32'h00040000, last_res, "after_abort");
    last_res = 32'h00040000;

    // Start held high: stays loading, never completes, resamples InpNum.
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      inp = (c == 29) ? 24'h018000 : 24'(c * 24'h001234);
      @(posedge clk); #1;
    end
    chk("held_start stop", {31'd0, stop}, 32'd0);
    chk("held_start result", result, last_res);
    start = 1'b0;
    inp   = 24'h000000;
    repeat (23) @(posedge clk);
    #1;
    chk("held_start stop_e23", {31'd0, stop}, 32'd0);
    @(posedge clk); #1;
    chk("held_start stop_e24", {31'd0, stop}, 32'd1);
    chk("held_start result_final", result, 32'h00024000);

    // Asynchronous reset mid-RUN.
    @(posedge clk); #1;
    start = 1'b1;
    inp   = 24'h020000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst stop", {31'd0, stop}, 32'd0);
    chk("async_rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst idle stop", {31'd0, stop}, 32'd0);
    chk("post_rst idle result", result, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
